// File: rtl/typed_stream_fifo.sv
// typed_stream_fifo: element-type-parameterised valid/ready FIFO, DEPTH entries (2..256, any value).
// Optional macro TYPED_STREAM_FIFO_BYPASS_EN: zero-latency pass-through while the FIFO is empty.
module typed_stream_fifo #(
  parameter type T     = int,
  parameter int  DEPTH = 4,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  T              in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output T              out_data_o,
  output logic [CW-1:0] count_o
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty, full;
  logic push, pop, pass;
  logic wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL);

  // Handshake: a side transfers on any rising edge where its valid and ready are both high;
  // in_ready_o depends only on occupancy, never on out_ready_i.
  always_comb begin
    in_ready_o  = !full;
    out_valid_o = !empty;
    out_data_o  = '0;
    if (!empty) begin
      out_data_o = mem_q[rp_q];
    end
`ifdef TYPED_STREAM_FIFO_BYPASS_EN
    if (empty) begin
      out_valid_o = in_valid_i;
      out_data_o  = in_data_i;
    end
`endif
  end

`ifdef TYPED_STREAM_FIFO_BYPASS_EN
  // A word that flows straight through counts as push and pop but leaves storage untouched.
  assign pass = empty && in_valid_i && out_ready_i;
`else
  assign pass = 1'b0;
`endif

  assign push  = in_valid_i && in_ready_o;
  assign pop   = out_valid_o && out_ready_i;
  assign wr_en = push && !pass;
  assign rd_en = pop && !pass;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      wp_d = (wp_q == LAST) ? '0 : wp_q + PW'(1);
    end
    if (rd_en) begin
      rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; its contents are masked while cnt_q is zero.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wp_q] <= in_data_i;
    end
  end

  assign count_o = cnt_q;

endmodule
